// File: rtl/frequency_generator.sv
// Square-wave source producing a BCD-selected number of rising edges per window.
// A repeated-add FSM converts the digits, and a phase accumulator spreads the edges evenly.
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int BITS          = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic       signal,
  output logic       busy,
  output logic       window,
  output logic [6:0] target
);

  typedef enum logic [1:0] {
    STATE_GEN  = 2'b00,
    STATE_CONV = 2'b01
  } state_t;

  localparam logic [BITS:0]   L_PERIOD = (BITS+1)'(UPDATE_PERIOD);
  localparam logic [BITS-1:0] L_LAST   = BITS'(UPDATE_PERIOD - 1);

  state_t          r_state;
  logic [3:0]      r_tens_left;
  logic [6:0]      r_target;
  logic            r_busy;
  logic [BITS:0]   r_acc;
  logic [BITS-1:0] r_clk_counter;
  logic            r_signal;
  logic            r_window;

  state_t          w_state_nxt;
  logic [3:0]      w_tens_nxt;
  logic [6:0]      w_target_nxt;
  logic            w_busy_nxt;
  logic [BITS:0]   w_acc_nxt;
  logic [BITS-1:0] w_cnt_nxt;
  logic            w_signal_nxt;
  logic            w_window_nxt;

  logic            w_last;
  logic [BITS:0]   w_step;
  logic [BITS:0]   w_sum;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Two accumulator steps per target edge: one for the rise, one for the fall.
  assign w_last = (r_clk_counter == L_LAST);
  assign w_step = {{(BITS-7){1'b0}}, r_target, 1'b0};
  assign w_sum  = r_acc + w_step;

  always_comb begin
    w_state_nxt  = r_state;
    w_tens_nxt   = r_tens_left;
    w_target_nxt = r_target;
    w_busy_nxt   = r_busy;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_clk_counter;
    w_signal_nxt = r_signal;
    w_window_nxt = 1'b0;
    case (r_state)
      STATE_GEN: begin
        w_window_nxt = w_last;
        if (load) begin
          w_tens_nxt   = clamp_bcd(ten_count);
          w_target_nxt = {3'b000, clamp_bcd(unit_count)};
          w_busy_nxt   = 1'b1;
          w_state_nxt  = STATE_CONV;
        end else begin
          w_cnt_nxt = w_last ? '0 : r_clk_counter + 1'b1;
          if (w_sum >= L_PERIOD) begin
            w_acc_nxt    = w_sum - L_PERIOD;
            w_signal_nxt = ~r_signal;
          end else begin
            w_acc_nxt = w_sum;
          end
        end
      end
      STATE_CONV: begin
        if (r_tens_left == 4'd0) begin
          // Restart the window aligned to the new target, starting low.
          w_state_nxt  = STATE_GEN;
          w_busy_nxt   = 1'b0;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_signal_nxt = 1'b0;
        end else begin
          w_target_nxt = r_target + 7'd10;
          w_tens_nxt   = r_tens_left - 4'd1;
        end
      end
      default: begin
        w_state_nxt  = STATE_GEN;
        w_busy_nxt   = 1'b0;
        w_acc_nxt    = '0;
        w_cnt_nxt    = '0;
        w_signal_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= STATE_GEN;
      r_tens_left   <= 4'd0;
      r_target      <= 7'd0;
      r_busy        <= 1'b0;
      r_acc         <= '0;
      r_clk_counter <= '0;
      r_signal      <= 1'b0;
      r_window      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tens_left   <= w_tens_nxt;
      r_target      <= w_target_nxt;
      r_busy        <= w_busy_nxt;
      r_acc         <= w_acc_nxt;
      r_clk_counter <= w_cnt_nxt;
      r_signal      <= w_signal_nxt;
      r_window      <= w_window_nxt;
    end
  end

  assign signal = r_signal;
  assign busy   = r_busy;
  assign window = r_window;
  assign target = r_target;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: per-cycle reference model, table of loads,
// hand-written corner sequences and randomized reloads.
module tb_frequency_generator;

  localparam int P = 1200;
  localparam int B = 12;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       signal;
  logic       busy;
  logic       window;
  logic [6:0] target;

  frequency_generator #(.UPDATE_PERIOD(P), .BITS(B)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .ten_count (ten_count),
    .unit_count(unit_count),
    .signal    (signal),
    .busy      (busy),
    .window    (window),
    .target    (target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: m_k = edges since the window restarted, m_n = active target
  int   m_k, m_n, m_conv_left, m_pending;
  logic exp_sig, exp_win, exp_busy;

  // edge statistics taken from the sampled DUT output
  int   rises, wins, high_run, chk_high_len;
  logic prev_sig;

  typedef struct {
    logic [3:0] ten;
    logic [3:0] unit;
    int         exp_target;
    int         exp_busy_cycles;
  } vec_t;
  vec_t tbl[8];

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_n = 0; m_conv_left = 0; m_pending = 0;
    exp_sig = 1'b0; exp_win = 1'b0; exp_busy = 1'b0;
    prev_sig = 1'b0; high_run = 0;
  endtask

  // One clock: drive inputs, advance the model on posedge, compare on negedge.
  task automatic step(input logic ld, input logic [3:0] t, input logic [3:0] u);
    load = ld; ten_count = t; unit_count = u;
    @(posedge clk);
    if (m_conv_left > 0) begin
      m_conv_left--;
      exp_win  = 1'b0;
      exp_busy = (m_conv_left > 0);
      if (m_conv_left == 0) begin
        m_k = 0; m_n = m_pending; exp_sig = 1'b0;
      end
    end else if (ld) begin
      exp_win     = ((m_k + 1) % P == 0);
      m_conv_left = clampd(t) + 1;
      m_pending   = 10 * clampd(t) + clampd(u);
      exp_busy    = 1'b1;
    end else begin
      m_k++;
      exp_sig = (((m_k * 2 * m_n) / P) % 2) == 1;
      exp_win = (m_k % P == 0);
    end
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (signal !== exp_sig || window !== exp_win || busy !== exp_busy ||
        (!exp_busy && target !== 7'(m_n))) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL cycle at %0t: signal %b/%b window %b/%b busy %b/%b target %0d/%0d (got/expected)",
                 $time, signal, exp_sig, window, exp_win, busy, exp_busy, target, m_n);
    end
    if (signal === 1'b1 && prev_sig === 1'b0) rises++;
    if (window === 1'b1) wins++;
    if (signal === 1'b1) high_run++;
    else if (prev_sig === 1'b1) begin
      if (chk_high_len != 0) check("high_len", high_run, chk_high_len);
      high_run = 0;
    end
    prev_sig = signal;
  endtask

  task automatic settle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      step(1'b0, 4'd0, 4'd0);
      cycles++;
    end
    if (busy === 1'b1) check("busy_timeout", 1, 0);
  endtask

  task automatic load_and_settle(input logic [3:0] t, input logic [3:0] u, output int busy_cycles);
    int n;
    step(1'b1, t, u);
    settle(n);
    busy_cycles = n;
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_signal", signal, 0);
    check("rst_busy", busy, 0);
    check("rst_window", window, 0);
    check("rst_target", target, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int bc;
    logic [3:0] t, u;
    tbl[0] = '{4'd0,  4'd5,  5,  1};
    tbl[1] = '{4'd4,  4'd2,  42, 5};
    tbl[2] = '{4'd12, 4'd15, 99, 10};
    tbl[3] = '{4'd9,  4'd0,  90, 10};
    tbl[4] = '{4'd0,  4'd0,  0,  1};
    tbl[5] = '{4'd9,  4'd9,  99, 10};
    tbl[6] = '{4'd3,  4'd10, 39, 4};
    tbl[7] = '{4'd15, 4'd1,  91, 10};

    reset_n = 1'b0; load = 1'b0; ten_count = 4'd0; unit_count = 4'd0;
    rises = 0; wins = 0; chk_high_len = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // idle after reset: constant low, window every P clocks
    wins = 0; rises = 0;
    repeat (2 * P) step(1'b0, 4'd0, 4'd0);
    check("idle_windows", wins, 2);
    check("idle_rises", rises, 0);

    // target 5: three windows, 120-clock high phases
    load_and_settle(4'd0, 4'd5, bc);
    check("t5_busy", bc, 1);
    rises = 0; chk_high_len = 120;
    repeat (3 * P) step(1'b0, 4'd0, 4'd0);
    chk_high_len = 0;
    check("t5_rises", rises, 15);

    // table of loads: busy length, converted target, edges in one window
    foreach (tbl[i]) begin
      load_and_settle(tbl[i].ten, tbl[i].unit, bc);
      check("tbl_busy", bc, tbl[i].exp_busy_cycles);
      check("tbl_target", target, tbl[i].exp_target);
      rises = 0;
      repeat (P) step(1'b0, 4'd0, 4'd0);
      check("tbl_rises", rises, tbl[i].exp_target);
    end

    // load while busy is ignored
    step(1'b1, 4'd9, 4'd0);
    step(1'b0, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0);
    step(1'b1, 4'd1, 4'd1);
    settle(bc);
    check("busy_load_target", target, 90);

    // reload mid-window 30 -> 7
    load_and_settle(4'd3, 4'd0, bc);
    repeat (500) step(1'b0, 4'd0, 4'd0);
    load_and_settle(4'd0, 4'd7, bc);
    rises = 0; wins = 0;
    repeat (2 * P) step(1'b0, 4'd0, 4'd0);
    check("reload_rises", rises, 14);
    check("reload_windows", wins, 2);

    // load coinciding with the window pulse
    begin
      int n = 0;
      while (m_k % P != P - 1 && n < P) begin
        step(1'b0, 4'd0, 4'd0);
        n++;
      end
    end
    wins = 0;
    step(1'b1, 4'd2, 4'd3);
    check("load_on_window_pulse", wins, 1);
    settle(bc);
    check("load_on_window_target", target, 23);

    // asynchronous reset mid-conversion, then clean restart
    step(1'b1, 4'd9, 4'd9);
    step(1'b0, 4'd0, 4'd0);
    step(1'b0, 4'd0, 4'd0);
    async_reset();
    load_and_settle(4'd0, 4'd3, bc);
    rises = 0;
    repeat (P) step(1'b0, 4'd0, 4'd0);
    check("post_reset_rises", rises, 3);

    // asynchronous reset mid-window
    repeat (300) step(1'b0, 4'd0, 4'd0);
    async_reset();
    repeat (P) step(1'b0, 4'd0, 4'd0);

    // randomized reloads, including loads during conversion
    for (int r = 0; r < 12; r++) begin
      t = 4'($urandom_range(0, 15));
      u = 4'($urandom_range(0, 15));
      step(1'b1, t, u);
      repeat ($urandom_range(0, 12))
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(50, 2000)) step(1'b0, 4'd0, 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
- Stimulus-side counterpart of the frequency counter: takes a two-digit BCD target (tens, units) and drives a square wave with exactly that many rising edges per measurement window of UPDATE_PERIOD clocks.
- Used as an on-chip loopback source to exercise the counter and seven-segment path, and as a standalone test-signal source.
- BCD-to-binary conversion is a sequential repeated-add FSM.
- Edge placement uses a phase accumulator so the N rising edges are spread evenly across the window.

Parameters:
- UPDATE_PERIOD, 1200, window length in clk cycles. Must satisfy 198 <= UPDATE_PERIOD < 2^BITS.
- BITS, 12, width of the window counter. The phase accumulator is BITS+1 bits.

Ports:
- clk  input  1  system clock (12 MHz on FPGA).
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; samples ten_count/unit_count.
- ten_count  input  4  BCD tens digit of target.
- unit_count  input  4  BCD units digit of target.
- signal  output  1  generated square wave.
- busy  output  1  high while BCD conversion is in progress; load is ignored while high.
- window  output  1  one-cycle pulse on the last clock of each window.
- target  output  7  binary edge count currently being generated (0..99).

Behaviour:
- Reset (async, reset_n low):
  - signal=0, busy=0, window=0, target=0.
  - acc=0, clk_counter=0, state=STATE_GEN.
  - With target 0 the generator outputs a constant low while window keeps pulsing.
- Digit clamp: any digit >9 is treated as 9. The tens and units digits clamp independently.
- FSM states: STATE_GEN, STATE_CONV. Any other encoding goes to STATE_GEN with acc=0, clk_counter=0, signal=0.
- STATE_GEN, load=1 on edge k:
  - Edge k: tens_left<=clamp(ten_count), target<=clamp(unit_count), busy<=1, state<=STATE_CONV.
  - Edge k: signal holds its current level; no toggle this cycle.
- STATE_CONV, each edge:
  - If tens_left==0: state<=STATE_GEN, busy<=0, acc<=0, clk_counter<=0, signal<=0.
  - Otherwise: target<=target+10, tens_left<=tens_left-1.
  - busy is therefore high for clamp(tens)+1 cycles. load is ignored throughout and window does not pulse.
- STATE_GEN, each edge (no load):
  - clk_counter <= (clk_counter==UPDATE_PERIOD-1) ? 0 : clk_counter+1.
  - window <= (clk_counter==UPDATE_PERIOD-1).
  - Let s = acc + 2*target, computed at BITS+1 width; max value is UPDATE_PERIOD-1+198, so no overflow.
  - If s >= UPDATE_PERIOD: acc<=s-UPDATE_PERIOD, signal<=~signal. Otherwise acc<=s.
- Window and edge-count properties:
  - acc returns to 0 exactly every UPDATE_PERIOD clocks.
  - Each full window starting at clk_counter==0 contains exactly 2*target toggles.
  - Signal starts low after conversion, so each window contains exactly target rising edges.
  - High and low phases differ by at most 1 clock.
- Boundary cases:
  - target=0: no toggles; signal stays 0.
  - target=99: 198 toggles per window; minimum half-period is floor(UPDATE_PERIOD/198) clocks.
  - load while busy: ignored, no queuing.
  - load in the same cycle as a window pulse: the load wins. Counters restart after conversion and the window pulse for that cycle is still emitted.
  - Reset mid-conversion or mid-window: immediate return to reset values; the next load starts from a clean state.
- Latency: first toggle for target N occurs ceil(UPDATE_PERIOD/(2N)) clocks after busy falls.

Test Plan:
- Reset checks:
  - Assert reset_n=0 mid-stream, asynchronous to clk -> signal, busy, window, target go to 0 immediately, without waiting for a clock edge.
  - After release -> window pulses every 1200 clocks and signal stays 0.
- load with ten=0, unit=5 -> busy high 1 cycle, target=5, then exactly 5 rising edges per 1200-clock window over 3 consecutive windows, with signal high for 120 clocks per period.
- load with ten=4, unit=2 -> busy high 5 cycles, target=42, then 42 rising edges per window. Loop the signal into frequency_counter and check the display reads 4/2.
- load with ten=12, unit=15 (non-BCD) -> clamped to target=99, 99 rising edges per window, no accumulator overflow (acc always < 1200).
- load(ten=9, unit=0) followed 3 cycles later by load(ten=1, unit=1) while busy -> second load ignored, target=90.
- Reload mid-window (target 30 -> 7) -> after conversion, window restarts at count 0 with signal low, and each full window has 7 edges.
